// File: rtl/prim_ram_1p_arb_pkg.sv
// Shared types for the single-port RAM arbiter and init sequencer.
package prim_ram_1p_arb_pkg;

    localparam int unsigned NumReq = 2;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } arb_state_e;

    typedef enum logic {
        OwnerA = 1'b0,
        OwnerB = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/prim_ram_1p_arb_rr.sv
// Two-way round-robin arbiter. The priority pointer always moves to the
// requester that lost (or did not ask), so contention alternates A, B, A, ...
module prim_ram_1p_arb_rr
    import prim_ram_1p_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o
);

    arb_owner_e prio_q;
    arb_owner_e prio_d;

    // A lone requester wins outright; on contention the pointer holder wins
    always_comb begin
        gnt_o  = '0;
        prio_d = prio_q;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = (prio_q == OwnerA) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
        if (gnt_o[0]) begin
            prio_d = OwnerB;
        end else if (gnt_o[1]) begin
            prio_d = OwnerA;
        end
    end

    // Priority pointer register, A holds priority out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= OwnerA;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/prim_ram_1p_arb.sv
// Zero-fill sequencer plus two-requester arbiter in front of a single-port
// SRAM. Read responses are steered back to whichever requester issued them.
module prim_ram_1p_arb
    import prim_ram_1p_arb_pkg::*;
#(
    parameter  int Width = 32,
    parameter  int Depth = 512,
    localparam int Aw    = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    output logic             init_done_o,

    input  logic             a_req_i,
    output logic             a_gnt_o,
    input  logic             a_write_i,
    input  logic [Aw-1:0]    a_addr_i,
    input  logic [Width-1:0] a_wdata_i,
    input  logic [Width-1:0] a_wmask_i,
    output logic             a_rvalid_o,
    output logic [Width-1:0] a_rdata_o,

    input  logic             b_req_i,
    output logic             b_gnt_o,
    input  logic             b_write_i,
    input  logic [Aw-1:0]    b_addr_i,
    input  logic [Width-1:0] b_wdata_i,
    input  logic [Width-1:0] b_wmask_i,
    output logic             b_rvalid_o,
    output logic [Width-1:0] b_rdata_o,

    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic [Aw-1:0]    mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    output logic [Width-1:0] mem_wmask_o,
    input  logic [Width-1:0] mem_rdata_i
);

    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

    arb_state_e         state_q;
    arb_state_e         state_d;
    logic [Aw-1:0]      cnt_q;
    logic [Aw-1:0]      cnt_d;
    logic               pend_q;
    logic               pend_d;
    arb_owner_e         owner_q;
    arb_owner_e         owner_d;
    logic               arb_en;
    logic [NumReq-1:0]  gnt;

    // Arbitration is only live while running and not being cleared
    assign arb_en = (state_q == StRun) && !clear_i;

    prim_ram_1p_arb_rr u_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (arb_en),
        .req_i ({b_req_i, a_req_i}),
        .gnt_o (gnt)
    );

    assign a_gnt_o     = gnt[0];
    assign b_gnt_o     = gnt[1];
    assign init_done_o = (state_q == StRun);

    // Fill sequencing: walk the counter through every word, then hand over to the arbiter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                if (clear_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LastAddr) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + Aw'(1);
                end
            end
            StRun: begin
                if (clear_i) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    // RAM port mux: fill writes during init, otherwise the granted requester's fields
    always_comb begin
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (state_q == StInit) begin
            mem_req_o   = 1'b1;
            mem_write_o = 1'b1;
            mem_addr_o  = cnt_q;
            mem_wmask_o = '1;
        end else if (gnt[0]) begin
            mem_req_o   = 1'b1;
            mem_write_o = a_write_i;
            mem_addr_o  = a_addr_i;
            mem_wdata_o = a_wdata_i;
            mem_wmask_o = a_wmask_i;
        end else if (gnt[1]) begin
            mem_req_o   = 1'b1;
            mem_write_o = b_write_i;
            mem_addr_o  = b_addr_i;
            mem_wdata_o = b_wdata_i;
            mem_wmask_o = b_wmask_i;
        end
    end

    // Remember who issued a granted read so next cycle's data goes to them
    always_comb begin
        pend_d  = 1'b0;
        owner_d = owner_q;
        if (gnt[0]) begin
            pend_d  = !a_write_i;
            owner_d = OwnerA;
        end else if (gnt[1]) begin
            pend_d  = !b_write_i;
            owner_d = OwnerB;
        end
    end

    // State, fill counter and read-return tracking registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StInit;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            owner_q <= OwnerA;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            owner_q <= owner_d;
        end
    end

    assign a_rvalid_o = pend_q && (owner_q == OwnerA);
    assign b_rvalid_o = pend_q && (owner_q == OwnerB);
    assign a_rdata_o  = mem_rdata_i;
    assign b_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_prim_ram_1p_arb.sv
// Directed and randomized bench for prim_ram_1p_arb with an 8-word RAM.
module tb_prim_ram_1p_arb;

    localparam int Width = 32;
    localparam int Depth = 8;
    localparam int Aw    = 3;

    typedef struct {
        logic             vld;
        logic             write;
        logic [Aw-1:0]    addr;
        logic [Width-1:0] wdata;
        logic [Width-1:0] wmask;
    } txn_t;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             init_done;
    logic             a_req, a_gnt, a_write, a_rvalid;
    logic [Aw-1:0]    a_addr;
    logic [Width-1:0] a_wdata, a_wmask, a_rdata;
    logic             b_req, b_gnt, b_write, b_rvalid;
    logic [Aw-1:0]    b_addr;
    logic [Width-1:0] b_wdata, b_wmask, b_rdata;
    logic             mem_req, mem_write;
    logic [Aw-1:0]    mem_addr;
    logic [Width-1:0] mem_wdata, mem_wmask, mem_rdata;

    logic             preload_en;
    logic [Aw-1:0]    preload_addr;
    logic [Width-1:0] preload_data;
    logic [Width-1:0] ram [Depth];

    logic [Width-1:0] ref_mem [Depth];
    txn_t             pa, pb, t;
    int               ref_turn;
    int               win;
    logic             exp_rv_a, exp_rv_b;
    logic [Width-1:0] exp_rd;

    int n_checks;
    int n_fail;

    prim_ram_1p_arb #(
        .Width (Width),
        .Depth (Depth)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .init_done_o (init_done),
        .a_req_i     (a_req),
        .a_gnt_o     (a_gnt),
        .a_write_i   (a_write),
        .a_addr_i    (a_addr),
        .a_wdata_i   (a_wdata),
        .a_wmask_i   (a_wmask),
        .a_rvalid_o  (a_rvalid),
        .a_rdata_o   (a_rdata),
        .b_req_i     (b_req),
        .b_gnt_o     (b_gnt),
        .b_write_i   (b_write),
        .b_addr_i    (b_addr),
        .b_wdata_i   (b_wdata),
        .b_wmask_i   (b_wmask),
        .b_rvalid_o  (b_rvalid),
        .b_rdata_o   (b_rdata),
        .mem_req_o   (mem_req),
        .mem_write_o (mem_write),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wmask_o (mem_wmask),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM stand-in with one-cycle read latency and a backdoor preload
    always @(posedge clk) begin
        if (preload_en) begin
            ram[preload_addr] <= preload_data;
        end else if (mem_req) begin
            if (mem_write) begin
                ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(
        input logic ar, input logic aw, input logic [Aw-1:0] aa,
        input logic [Width-1:0] awd, input logic [Width-1:0] awm,
        input logic br, input logic bw, input logic [Aw-1:0] ba,
        input logic [Width-1:0] bwd, input logic [Width-1:0] bwm);
        a_req = ar; a_write = aw; a_addr = aa; a_wdata = awd; a_wmask = awm;
        b_req = br; b_write = bw; b_addr = ba; b_wdata = bwd; b_wmask = bwm;
        preload_en = 1'b0;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic preloadWord(input logic [Aw-1:0] addr, input logic [Width-1:0] data);
        @(negedge clk);
        applyIdle();
        preload_en   = 1'b1;
        preload_addr = addr;
        preload_data = data;
        ref_mem[addr] = data;
        #1;
        checkFlag("preload_idle_mem_req", mem_req, 1'b0);
    endtask

    function automatic txn_t newTxn();
        txn_t n;
        n.vld   = 1'b1;
        n.write = 1'($urandom);
        n.addr  = Aw'($urandom_range(0, Depth - 1));
        n.wdata = $urandom;
        n.wmask = $urandom;
        return n;
    endfunction

    // One fill cycle: the sequencer must own the port and write zeros
    task automatic checkFillCycle(input int k);
        checkFlag("fill_init_done", init_done, 1'b0);
        checkFlag("fill_mem_req", mem_req, 1'b1);
        checkFlag("fill_mem_write", mem_write, 1'b1);
        checkOutput("fill_mem_addr", 32'(mem_addr), 32'(k));
        checkOutput("fill_mem_wdata", mem_wdata, 32'h0);
        checkOutput("fill_mem_wmask", mem_wmask, 32'hFFFF_FFFF);
        checkFlag("fill_a_gnt", a_gnt, 1'b0);
        checkFlag("fill_b_gnt", b_gnt, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clear    = 1'b0;
        preload_addr = '0;
        preload_data = '0;
        applyIdle();
        for (int i = 0; i < Depth; i++) ref_mem[i] = '0;

        // Reset values while reset is held
        @(negedge clk);
        #1;
        checkFlag("rst_init_done", init_done, 1'b0);
        checkFlag("rst_a_gnt", a_gnt, 1'b0);
        checkFlag("rst_b_gnt", b_gnt, 1'b0);
        checkFlag("rst_a_rvalid", a_rvalid, 1'b0);
        checkFlag("rst_b_rvalid", b_rvalid, 1'b0);
        checkFlag("rst_mem_req", mem_req, 1'b1);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);

        // Release and watch the fill; both requesters ask throughout
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < Depth; k++) begin
            if (k > 0) @(negedge clk);
            applyStimulus(1'b1, 1'b0, 3'd1, '0, '0, 1'b1, 1'b0, 3'd2, '0, '0);
            #1;
            checkFillCycle(k);
        end
        @(negedge clk);
        applyIdle();
        #1;
        checkFlag("init_done_rise", init_done, 1'b1);
        checkFlag("run_idle_mem_req", mem_req, 1'b0);

        preloadWord(3'd1, 32'hAAAA_0001);
        preloadWord(3'd2, 32'hBBBB_0002);
        preloadWord(3'd3, 32'hDEAD_BEEF);

        // Contention from the reset pointer: A, B, A, B
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 3'd1, '0, '0, 1'b1, 1'b0, 3'd2, '0, '0);
            #1;
            checkFlag("rr_a_gnt", a_gnt, (c % 2) == 0);
            checkFlag("rr_b_gnt", b_gnt, (c % 2) == 1);
            checkOutput("rr_mem_addr", 32'(mem_addr), ((c % 2) == 0) ? 32'd1 : 32'd2);
            if (c > 0) begin
                checkFlag("rr_a_rvalid", a_rvalid, ((c - 1) % 2) == 0);
                checkFlag("rr_b_rvalid", b_rvalid, ((c - 1) % 2) == 1);
                checkOutput("rr_rdata", ((c - 1) % 2 == 0) ? a_rdata : b_rdata,
                            ((c - 1) % 2 == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002);
            end
        end
        @(negedge clk);
        applyIdle();
        #1;
        checkFlag("rr_last_b_rvalid", b_rvalid, 1'b1);
        checkFlag("rr_last_a_rvalid", a_rvalid, 1'b0);
        checkOutput("rr_last_b_rdata", b_rdata, 32'hBBBB_0002);

        // Single read by A
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 3'd3, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checkFlag("rd_a_gnt", a_gnt, 1'b1);
        checkFlag("rd_b_gnt", b_gnt, 1'b0);
        checkOutput("rd_mem_addr", 32'(mem_addr), 32'd3);
        checkFlag("rd_mem_write", mem_write, 1'b0);
        @(negedge clk);
        applyIdle();
        #1;
        checkFlag("rd_a_rvalid", a_rvalid, 1'b1);
        checkOutput("rd_a_rdata", a_rdata, 32'hDEAD_BEEF);
        checkFlag("rd_b_rvalid", b_rvalid, 1'b0);

        // Masked write by B, read back by A
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 3'd5, 32'h1234_5678, 32'h0000_FFFF);
        #1;
        checkFlag("wr_b_gnt", b_gnt, 1'b1);
        checkFlag("wr_mem_write", mem_write, 1'b1);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'd5);
        checkOutput("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        checkOutput("wr_mem_wmask", mem_wmask, 32'h0000_FFFF);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 3'd5, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checkFlag("wr_no_b_rvalid", b_rvalid, 1'b0);
        checkFlag("wr_rd_a_gnt", a_gnt, 1'b1);
        @(negedge clk);
        applyIdle();
        #1;
        checkFlag("wr_rd_a_rvalid", a_rvalid, 1'b1);
        checkOutput("wr_rd_a_rdata", a_rdata, 32'h0000_5678);
        ref_mem[5] = 32'h0000_5678;

        // Clear right after an A read grant, A keeps asking through the refill
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 3'd3, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checkFlag("clr_pre_a_gnt", a_gnt, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 3'd3, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        clear = 1'b1;
        #1;
        checkFlag("clr_a_gnt", a_gnt, 1'b0);
        checkFlag("clr_mem_req", mem_req, 1'b0);
        checkFlag("clr_a_rvalid", a_rvalid, 1'b1);
        checkOutput("clr_a_rdata", a_rdata, 32'hDEAD_BEEF);
        for (int k = 0; k < Depth; k++) begin
            @(negedge clk);
            clear = 1'b0;
            applyStimulus(1'b1, 1'b0, 3'd3, '0, '0, 1'b0, 1'b0, '0, '0, '0);
            #1;
            checkFillCycle(k);
        end
        for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 3'd3, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checkFlag("refill_done", init_done, 1'b1);
        checkFlag("refill_a_gnt", a_gnt, 1'b1);
        @(negedge clk);
        applyIdle();
        #1;
        checkFlag("refill_a_rvalid", a_rvalid, 1'b1);
        checkOutput("refill_a_rdata", a_rdata, 32'h0);

        // Randomized traffic; the last grant went to A so B holds priority
        ref_turn = 1;
        pa.vld = 1'b0;
        pb.vld = 1'b0;
        exp_rv_a = 1'b0;
        exp_rv_b = 1'b0;
        exp_rd = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!pa.vld && $urandom_range(0, 99) < 60) pa = newTxn();
            if (!pb.vld && $urandom_range(0, 99) < 60) pb = newTxn();
            applyStimulus(pa.vld, pa.write, pa.addr, pa.wdata, pa.wmask,
                          pb.vld, pb.write, pb.addr, pb.wdata, pb.wmask);
            #1;
            if (pa.vld && pb.vld) win = ref_turn;
            else if (pa.vld)      win = 0;
            else if (pb.vld)      win = 1;
            else                  win = -1;
            checkFlag("rnd_a_gnt", a_gnt, win == 0);
            checkFlag("rnd_b_gnt", b_gnt, win == 1);
            checkFlag("rnd_mem_req", mem_req, win >= 0);
            checkFlag("rnd_a_rvalid", a_rvalid, exp_rv_a);
            checkFlag("rnd_b_rvalid", b_rvalid, exp_rv_b);
            if (exp_rv_a) checkOutput("rnd_a_rdata", a_rdata, exp_rd);
            if (exp_rv_b) checkOutput("rnd_b_rdata", b_rdata, exp_rd);
            exp_rv_a = 1'b0;
            exp_rv_b = 1'b0;
            if (win >= 0) begin
                t = (win == 0) ? pa : pb;
                checkOutput("rnd_mem_addr", 32'(mem_addr), 32'(t.addr));
                checkFlag("rnd_mem_write", mem_write, t.write);
                if (t.write) begin
                    checkOutput("rnd_mem_wdata", mem_wdata, t.wdata);
                    checkOutput("rnd_mem_wmask", mem_wmask, t.wmask);
                    ref_mem[t.addr] = (ref_mem[t.addr] & ~t.wmask) | (t.wdata & t.wmask);
                end else begin
                    exp_rd   = ref_mem[t.addr];
                    exp_rv_a = (win == 0);
                    exp_rv_b = (win == 1);
                end
                ref_turn = 1 - win;
                if (win == 0) pa.vld = 1'b0;
                else          pb.vld = 1'b0;
            end
        end

        // Reset while a read response is due drops it
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checkFlag("rnd_tail_a_rvalid", a_rvalid, exp_rv_a);
        checkFlag("rnd_tail_b_rvalid", b_rvalid, exp_rv_b);
        if (exp_rv_a) checkOutput("rnd_tail_a_rdata", a_rdata, exp_rd);
        if (exp_rv_b) checkOutput("rnd_tail_b_rdata", b_rdata, exp_rd);
        checkFlag("rst2_pre_a_gnt", a_gnt, 1'b1);
        @(negedge clk);
        applyIdle();
        #1;
        checkFlag("rst2_pre_a_rvalid", a_rvalid, 1'b1);
        rst = 1'b1;
        #1;
        checkFlag("rst2_a_rvalid", a_rvalid, 1'b0);
        checkFlag("rst2_b_rvalid", b_rvalid, 1'b0);
        checkFlag("rst2_init_done", init_done, 1'b0);
        checkFlag("rst2_mem_req", mem_req, 1'b1);
        checkOutput("rst2_mem_addr", 32'(mem_addr), 32'h0);

        // Reset again in the middle of the fill
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(negedge clk);
            applyIdle();
            #1;
            checkFillCycle(k);
        end
        rst = 1'b1;
        #1;
        checkOutput("rst3_mem_addr", 32'(mem_addr), 32'h0);
        checkFlag("rst3_init_done", init_done, 1'b0);
        checkFlag("rst3_mem_req", mem_req, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < Depth; k++) begin
            if (k > 0) @(negedge clk);
            applyIdle();
            #1;
            checkFillCycle(k);
        end

        // Pointer is back at A after reset
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 3'd6, '0, '0, 1'b1, 1'b0, 3'd7, '0, '0);
        #1;
        checkFlag("post_rst_done", init_done, 1'b1);
        checkFlag("post_rst_a_gnt", a_gnt, 1'b1);
        checkFlag("post_rst_b_gnt", b_gnt, 1'b0);
        @(negedge clk);
        applyIdle();
        #1;
        checkFlag("post_rst_a_rvalid", a_rvalid, 1'b1);
        checkOutput("post_rst_a_rdata", a_rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
